pulse_rx: RTL



---
 rtl/delay_line_pkg.sv | 17 +
 rtl/sync_edge.sv | 36 +++
 rtl/pulse_rx.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/delay_line_pkg.sv
// Definitions shared by the delay-line burst transmitter and the echo receiver,
// so both ends agree on the burst shape and on the receiver state encoding.
package delay_line_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        HIGH  = 2'd2,
        LOW   = 2'd3
    } rx_state_e;

    localparam int DEF_CLKS_PER_HALF_PERIOD = 2;
    localparam int DEF_PULSES               = 3;
    localparam int DEF_TIMEOUT_CLKS         = 1024;
    localparam int DEF_TOF_W                = $clog2(DEF_TIMEOUT_CLKS);

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchroniser for the asynchronous echo input, followed by one
// delay flop so that rising and falling edges can be decoded.
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   dly_q, dly_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
        dly_d  = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            dly_q  <= dly_d;
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = sync_q[SYNC_STAGES-1] & ~dly_q;
    assign fall  = ~sync_q[SYNC_STAGES-1] & dly_q;

endmodule

// File: rtl/pulse_rx.sv
// Echo burst receiver: arms on start, validates PULSES square pulses on the
// synchronised input and reports the time of flight, or a timeout.
module pulse_rx
    import delay_line_pkg::*;
#(
    parameter int CLKS_PER_HALF_PERIOD = DEF_CLKS_PER_HALF_PERIOD,
    parameter int PULSES               = DEF_PULSES,
    parameter int TOLERANCE            = 1,
    parameter int TIMEOUT_CLKS         = DEF_TIMEOUT_CLKS,
    parameter int SYNC_STAGES          = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic                            in,
    output logic [$clog2(TIMEOUT_CLKS)-1:0] tof,
    output logic                            valid,
    output logic                            timeout,
    output logic                            busy
);

    localparam int TW = $clog2(TIMEOUT_CLKS);
    localparam int WW = $clog2(CLKS_PER_HALF_PERIOD + TOLERANCE + 2);
    localparam int PW = (PULSES > 1) ? $clog2(PULSES) : 1;

    localparam logic [TW-1:0] LAST_CNT   = TW'(TIMEOUT_CLKS - 1);
    localparam logic [WW-1:0] W_MIN      = WW'(CLKS_PER_HALF_PERIOD - TOLERANCE);
    localparam logic [WW-1:0] W_MAX      = WW'(CLKS_PER_HALF_PERIOD + TOLERANCE);
    localparam logic [PW-1:0] LAST_PULSE = PW'(PULSES - 1);

    rx_state_e     state_q, state_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] cand_q, cand_d;
    logic [TW-1:0] tof_q, tof_d;
    logic [WW-1:0] width_cnt_q, width_cnt_d;
    logic [PW-1:0] pulse_cnt_q, pulse_cnt_d;
    logic          valid_q, valid_d;
    logic          timeout_q, timeout_d;

    logic          level, rise, fall;
    logic          busy_w, tmo_hit, width_ok, done;
    logic [WW-1:0] len_now, len_ext;

    sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .din  (in),
        .level(level),
        .rise (rise),
        .fall (fall)
    );

    // width_cnt excludes the edge cycle: a completed phase spans width_cnt+1
    // cycles, a phase that is still running spans width_cnt+2 after this one.
    assign len_now  = width_cnt_q + WW'(1);
    assign len_ext  = width_cnt_q + WW'(2);
    assign width_ok = (len_now >= W_MIN) && (len_now <= W_MAX);
    assign busy_w   = (state_q != IDLE);
    assign tmo_hit  = busy_w && (cnt_q == LAST_CNT);
    assign done     = (state_q == HIGH) && fall && width_ok && (pulse_cnt_q == LAST_PULSE);

    always_comb begin
        state_d     = state_q;
        cnt_d       = busy_w ? cnt_q + TW'(1) : cnt_q;
        cand_d      = cand_q;
        tof_d       = tof_q;
        width_cnt_d = width_cnt_q;
        pulse_cnt_d = pulse_cnt_q;
        valid_d     = 1'b0;
        timeout_d   = 1'b0;

        // A finished burst is reported even when start arrives on the same edge.
        if (done && !tmo_hit) begin
            valid_d = 1'b1;
            tof_d   = cand_q;
        end

        if (start) begin
            state_d     = ARMED;
            cnt_d       = '0;
            pulse_cnt_d = '0;
            width_cnt_d = '0;
        end else if (tmo_hit) begin
            state_d   = IDLE;
            timeout_d = 1'b1;
        end else begin
            case (state_q)
                ARMED: begin
                    if (rise) begin
                        state_d     = HIGH;
                        cand_d      = cnt_q;
                        pulse_cnt_d = '0;
                        width_cnt_d = '0;
                    end
                end
                HIGH: begin
                    if (fall) begin
                        if (!width_ok) begin
                            state_d = ARMED;
                        end else if (pulse_cnt_q == LAST_PULSE) begin
                            state_d = IDLE;
                        end else begin
                            state_d     = LOW;
                            pulse_cnt_d = pulse_cnt_q + PW'(1);
                            width_cnt_d = '0;
                        end
                    end else if (level && (len_ext > W_MAX)) begin
                        state_d = ARMED;
                    end else begin
                        width_cnt_d = width_cnt_q + WW'(1);
                    end
                end
                LOW: begin
                    if (rise) begin
                        state_d     = HIGH;
                        width_cnt_d = '0;
                        // Too short a gap means this rise opens a fresh train.
                        if (len_now < W_MIN) begin
                            cand_d      = cnt_q;
                            pulse_cnt_d = '0;
                        end
                    end else if (!level && (len_ext > W_MAX)) begin
                        state_d = ARMED;
                    end else begin
                        width_cnt_d = width_cnt_q + WW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cand_q      <= '0;
            tof_q       <= '0;
            width_cnt_q <= '0;
            pulse_cnt_q <= '0;
            valid_q     <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cand_q      <= cand_d;
            tof_q       <= tof_d;
            width_cnt_q <= width_cnt_d;
            pulse_cnt_q <= pulse_cnt_d;
            valid_q     <= valid_d;
            timeout_q   <= timeout_d;
        end
    end

    assign tof     = tof_q;
    assign valid   = valid_q;
    assign timeout = timeout_q;
    assign busy    = busy_w;

endmodule
